// File: rtl/axi_pkg.sv
// Shared AXI response/burst codes and the slave memory FSM state encoding.
package axi_pkg;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    StIdle,
    StWdata,
    StWresp,
    StRdata
  } state_e;

  // Response codes are ordered so that the numerically larger one wins.
  function automatic resp_e resp_max(resp_e a, resp_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_slave_ram.sv
// DEPTH x DATA_W storage with a byte-enable write port and a registered read port.
module axi_slave_ram #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_W/8-1:0]        wstrb_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_W-1:0]          rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read register holds its value while re_i is low, giving stall-stable data.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 memory slave: one burst at a time, FIXED/INCR supported, per-beat range decode.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic [3:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awcache,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awqos,
  input  logic [3:0]            s_axi_awregion,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic [3:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arcache,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arqos,
  input  logic [3:0]            s_axi_arregion,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int unsigned       StrbW    = DATA_W / 8;
  localparam int unsigned       OffW     = $clog2(StrbW);
  localparam int unsigned       IdxW     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] MemBytes = ADDR_W'(DEPTH * StrbW);
  localparam logic [2:0]        FullSize = 3'(OffW);

  function automatic logic [ADDR_W-1:0] next_addr(logic [ADDR_W-1:0] a, logic [2:0] size,
                                                  logic [1:0] burst);
    if (burst == BurstFixed) return a;
    return a + (ADDR_W'(1) << size);
  endfunction

  function automatic logic desc_bad(logic [2:0] size, logic [1:0] burst);
    return (burst == BurstWrap) || (size != FullSize);
  endfunction

  function automatic resp_e beat_resp(logic [ADDR_W-1:0] a, logic desc_err);
    resp_e r;
    r = desc_err ? RespSlverr : RespOkay;
    if ((a - BASE_ADDR) >= MemBytes) r = RespDecerr;
    return r;
  endfunction

  function automatic logic [IdxW-1:0] word_idx(logic [ADDR_W-1:0] a);
    return IdxW'((a - BASE_ADDR) >> OffW);
  endfunction

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_q, cnt_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              desc_err_q;
  resp_e             bresp_q, rresp_q;
  logic              bvalid_q, rvalid_q, rlast_q, rzero_q;

  logic [ADDR_W-1:0] addr_nxt;
  logic              last_beat, aw_hs, ar_hs, r_adv;
  resp_e             w_resp, wlast_resp, ar_resp, rn_resp;
  logic              ram_we, ram_re;
  logic [IdxW-1:0]   ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  assign addr_nxt   = next_addr(addr_q, size_q, burst_q);
  assign last_beat  = (cnt_q == len_q);
  assign aw_hs      = (state_q == StIdle) && s_axi_awvalid;
  assign ar_hs      = (state_q == StIdle) && !s_axi_awvalid && s_axi_arvalid;
  assign r_adv      = (state_q == StRdata) && s_axi_rready && !rlast_q;
  assign w_resp     = beat_resp(addr_q, desc_err_q);
  assign wlast_resp = (s_axi_wlast != last_beat) ? RespSlverr : RespOkay;
  assign ar_resp    = beat_resp(s_axi_araddr, desc_bad(s_axi_arsize, s_axi_arburst));
  assign rn_resp    = beat_resp(addr_nxt, desc_err_q);

  // A beat landing on the reset edge is dropped along with the rest of the burst.
  assign ram_we    = (state_q == StWdata) && s_axi_wvalid && (w_resp == RespOkay) && !areset;
  assign ram_waddr = word_idx(addr_q);
  assign ram_re    = ar_hs || r_adv;
  assign ram_raddr = ar_hs ? word_idx(s_axi_araddr) : word_idx(addr_nxt);

  axi_slave_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wstrb_i (s_axi_wstrb),
    .wdata_i (s_axi_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      desc_err_q <= 1'b0;
      bresp_q    <= RespOkay;
      rresp_q    <= RespOkay;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rzero_q    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (aw_hs) begin
            addr_q     <= s_axi_awaddr;
            len_q      <= s_axi_awlen;
            size_q     <= s_axi_awsize;
            burst_q    <= s_axi_awburst;
            cnt_q      <= '0;
            desc_err_q <= desc_bad(s_axi_awsize, s_axi_awburst);
            bresp_q    <= RespOkay;
            state_q    <= StWdata;
          end else if (ar_hs) begin
            addr_q     <= s_axi_araddr;
            len_q      <= s_axi_arlen;
            size_q     <= s_axi_arsize;
            burst_q    <= s_axi_arburst;
            cnt_q      <= '0;
            desc_err_q <= desc_bad(s_axi_arsize, s_axi_arburst);
            rresp_q    <= ar_resp;
            rzero_q    <= (ar_resp != RespOkay);
            rvalid_q   <= 1'b1;
            rlast_q    <= (s_axi_arlen == 4'd0);
            state_q    <= StRdata;
          end
        end
        StWdata: begin
          if (s_axi_wvalid) begin
            bresp_q <= resp_max(resp_max(bresp_q, w_resp), wlast_resp);
            addr_q  <= addr_nxt;
            cnt_q   <= cnt_q + 4'd1;
            if (last_beat) begin
              bvalid_q <= 1'b1;
              state_q  <= StWresp;
            end
          end
        end
        StWresp: begin
          if (s_axi_bready) begin
            bvalid_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StRdata: begin
          if (s_axi_rready) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state_q  <= StIdle;
            end else begin
              addr_q  <= addr_nxt;
              cnt_q   <= cnt_q + 4'd1;
              rlast_q <= ((cnt_q + 4'd1) == len_q);
              rresp_q <= rn_resp;
              rzero_q <= (rn_resp != RespOkay);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_axi_awready = (state_q == StIdle);
  assign s_axi_arready = (state_q == StIdle) && !s_axi_awvalid;
  assign s_axi_wready  = (state_q == StWdata);
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rzero_q ? '0 : ram_rdata;

  logic unused_sideband;
  assign unused_sideband = ^{s_axi_awprot, s_axi_awcache, s_axi_awlock, s_axi_awqos,
                             s_axi_awregion, s_axi_arprot, s_axi_arcache, s_axi_arlock,
                             s_axi_arqos, s_axi_arregion};

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem against a byte-array reference model.
module tb_axi_slave_mem;

  localparam int MEMB = 256 * 8;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [3:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = 3'd3, arsize = 3'd3;
  logic [1:0]  awburst = 2'd1, arburst = 2'd1;
  logic        awvalid = 1'b0, arvalid = 1'b0, awready, arready;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0, wvalid = 1'b0, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready = 1'b0;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready = 1'b0;
  logic [2:0]  prot = '0;
  logic [3:0]  nib = '0;
  logic        lock = 1'b0;

  always #5 aclk = ~aclk;

  axi_slave_mem #(
    .ADDR_W    (32),
    .DATA_W    (64),
    .DEPTH     (256),
    .BASE_ADDR (32'h0)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_axi_awaddr   (awaddr),
    .s_axi_awlen    (awlen),
    .s_axi_awsize   (awsize),
    .s_axi_awburst  (awburst),
    .s_axi_awprot   (prot),
    .s_axi_awcache  (nib),
    .s_axi_awlock   (lock),
    .s_axi_awqos    (nib),
    .s_axi_awregion (nib),
    .s_axi_awvalid  (awvalid),
    .s_axi_awready  (awready),
    .s_axi_wdata    (wdata),
    .s_axi_wstrb    (wstrb),
    .s_axi_wlast    (wlast),
    .s_axi_wvalid   (wvalid),
    .s_axi_wready   (wready),
    .s_axi_bresp    (bresp),
    .s_axi_bvalid   (bvalid),
    .s_axi_bready   (bready),
    .s_axi_araddr   (araddr),
    .s_axi_arlen    (arlen),
    .s_axi_arsize   (arsize),
    .s_axi_arburst  (arburst),
    .s_axi_arprot   (prot),
    .s_axi_arcache  (nib),
    .s_axi_arlock   (lock),
    .s_axi_arqos    (nib),
    .s_axi_arregion (nib),
    .s_axi_arvalid  (arvalid),
    .s_axi_arready  (arready),
    .s_axi_rdata    (rdata),
    .s_axi_rresp    (rresp),
    .s_axi_rlast    (rlast),
    .s_axi_rvalid   (rvalid),
    .s_axi_rready   (rready)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  mdl [MEMB];
  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  int          rd_n;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  exp;
  } vec_t;
  vec_t vt [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference rules: FIXED holds the address, anything else steps by 2^size.
  function automatic logic [31:0] beat_addr(logic [31:0] start, logic [2:0] size,
                                            logic [1:0] burst, int i);
    if (burst == 2'd0) return start;
    return start + (32'(i) << size);
  endfunction

  function automatic logic [1:0] beat_resp(logic [31:0] a, logic [2:0] size, logic [1:0] burst);
    logic [1:0] r;
    r = 2'd0;
    if (burst == 2'd2 || size != 3'd3) r = 2'd2;
    if (a >= 32'(MEMB)) r = 2'd3;
    return r;
  endfunction

  function automatic logic wl_of(int mode, int i, int len);
    if (mode == 1) return 1'b0;
    if (mode == 2) return (i == len) || (i == 0);
    return i == len;
  endfunction

  function automatic logic [63:0] mdl_word(logic [31:0] a);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[8*b +: 8] = mdl[int'(a[10:3]) * 8 + b];
    return w;
  endfunction

  task automatic mdl_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input int mode, output logic [1:0] resp);
    logic [31:0] a;
    logic [1:0]  br;
    resp = 2'd0;
    for (int i = 0; i <= len; i++) begin
      a  = beat_addr(addr, size, burst, i);
      br = beat_resp(a, size, burst);
      if (br == 2'd0) begin
        for (int b = 0; b < 8; b++) begin
          if (ws[i][b]) mdl[int'(a[10:3]) * 8 + b] = wd[i][8*b +: 8];
        end
      end
      if (br > resp) resp = br;
      if (wl_of(mode, i, len) != (i == len) && resp < 2'd2) resp = 2'd2;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input int mode, output logic [1:0] resp);
    int t;
    int hold;
    awaddr = addr; awlen = 4'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(posedge aclk); #1; t++; end
    check("aw_timeout", 64'(t >= 50), 64'(0));
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = wl_of(mode, i, len);
      t = 0;
      while (!wready && t < 50) begin @(posedge aclk); #1; t++; end
      check("w_timeout", 64'(t >= 50), 64'(0));
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("b_latency", 64'(bvalid), 64'(1));
    resp = bresp;
    hold = $urandom_range(0, 2);
    for (int k = 0; k < hold; k++) begin
      @(posedge aclk); #1;
      check("b_hold", 64'({bvalid, bresp}), 64'({1'b1, resp}));
    end
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin @(posedge aclk); #1; t++; end
    resp = bresp;
    @(posedge aclk); #1;
    bready = 1'b0;
    check("b_done", 64'(bvalid), 64'(0));
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input int mode);
    int t;
    int cyc;
    logic stall;
    logic [66:0] prev;
    araddr = addr; arlen = 4'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(posedge aclk); #1; t++; end
    check("ar_timeout", 64'(t >= 50), 64'(0));
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("r_latency", 64'(rvalid), 64'(1));
    rd_n = 0; cyc = 0; stall = 1'b0; prev = '0;
    while (rd_n <= len && cyc < 200) begin
      if (mode == 0) rready = 1'b1;
      else if (mode == 1) rready = (cyc % 2 == 0);
      else rready = 1'($urandom_range(0, 1));
      check("r_valid", 64'(rvalid), 64'(1));
      if (stall) begin
        check("r_stable_data", rdata, prev[66:3]);
        check("r_stable_ctl", 64'({rresp, rlast}), 64'(prev[2:0]));
      end
      if (rready) begin
        rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast;
        rd_n++;
        stall = 1'b0;
      end else begin
        stall = 1'b1;
        prev = {rdata, rresp, rlast};
      end
      @(posedge aclk); #1;
      cyc++;
    end
    rready = 1'b0;
    check("r_beats", 64'(rd_n), 64'(len + 1));
    check("r_idle", 64'(rvalid), 64'(0));
  endtask

  task automatic check_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input int mode);
    logic [31:0] a;
    logic [1:0]  er;
    int nlast;
    do_read(addr, len, size, burst, mode);
    nlast = 0;
    for (int i = 0; i < rd_n && i <= len; i++) begin
      a  = beat_addr(addr, size, burst, i);
      er = beat_resp(a, size, burst);
      check($sformatf("rdata[%0d]@%h", i, a), rd_data[i], (er == 2'd0) ? mdl_word(a) : 64'd0);
      check($sformatf("rresp[%0d]@%h", i, a), 64'(rd_resp[i]), 64'(er));
      check($sformatf("rlast[%0d]", i), 64'(rd_last[i]), 64'(i == len));
      if (rd_last[i]) nlast++;
    end
    check("rlast_count", 64'(nlast), 64'(1));
  endtask

  task automatic write_chk(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input int mode, output logic [1:0] got);
    logic [1:0] exp;
    mdl_write(addr, len, size, burst, mode, exp);
    do_write(addr, len, size, burst, mode, got);
    check($sformatf("bresp@%h", addr), 64'(got), 64'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r;
    logic [63:0] e38 [4];
    logic [31:0] a;
    int          len;

    vt[0] = '{32'h0000_0000, 4'd3, 3'd3, 2'd1, 2'd0};
    vt[1] = '{32'h0000_0100, 4'd0, 3'd3, 2'd0, 2'd0};
    vt[2] = '{32'h0000_0200, 4'd2, 3'd3, 2'd2, 2'd2};
    vt[3] = '{32'h0000_0300, 4'd1, 3'd2, 2'd1, 2'd2};
    vt[4] = '{32'h0000_07F8, 4'd1, 3'd3, 2'd1, 2'd3};
    vt[5] = '{32'h0000_0800, 4'd0, 3'd3, 2'd1, 2'd3};
    vt[6] = '{32'h0000_0400, 4'd7, 3'd3, 2'd0, 2'd0};
    vt[7] = '{32'h0000_07F0, 4'd3, 3'd3, 2'd1, 2'd3};
    vt[8] = '{32'hFFFF_FFF8, 4'd1, 3'd3, 2'd1, 2'd3};

    // Reset values, sampled while reset is still asserted.
    repeat (3) @(posedge aclk);
    #1;
    check("rst_bvalid", 64'(bvalid), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_rlast", 64'(rlast), 64'(0));
    check("rst_bresp", 64'(bresp), 64'(0));
    check("rst_rresp", 64'(rresp), 64'(0));
    check("rst_rdata", rdata, 64'(0));
    check("rst_wready", 64'(wready), 64'(0));
    areset = 1'b0;
    #1;
    check("rst_awready", 64'(awready), 64'(1));
    check("rst_arready", 64'(arready), 64'(1));
    @(posedge aclk); #1;

    // Fill the whole memory so every read has a known reference.
    for (int blk = 0; blk < 16; blk++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      write_chk(32'(blk * 128), 15, 3'd3, 2'd1, 0, r);
    end

    // Basic INCR write then read back.
    e38[0] = 64'h11; e38[1] = 64'h22; e38[2] = 64'h33; e38[3] = 64'h44;
    for (int i = 0; i < 4; i++) begin wd[i] = e38[i]; ws[i] = 8'hFF; end
    write_chk(32'h0, 3, 3'd3, 2'd1, 0, r);
    check("basic_bresp", 64'(r), 64'(0));
    check_read(32'h0, 3, 3'd3, 2'd1, 0);
    for (int i = 0; i < 4; i++) check($sformatf("basic_rd[%0d]", i), rd_data[i], e38[i]);

    // Partial strobe over all-ones.
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    write_chk(32'h8, 0, 3'd3, 2'd1, 0, r);
    wd[0] = 64'h0; ws[0] = 8'h0F;
    write_chk(32'h8, 0, 3'd3, 2'd1, 0, r);
    check_read(32'h8, 0, 3'd3, 2'd1, 0);
    check("strb_rd", rd_data[0], 64'hFFFF_FFFF_0000_0000);

    // Descriptor table: write, check bresp against the table and model, read back.
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      write_chk(vt[v].addr, int'(vt[v].len), vt[v].size, vt[v].burst, 0, r);
      check($sformatf("vec%0d_bresp", v), 64'(r), 64'(vt[v].exp));
      check_read(vt[v].addr, int'(vt[v].len), vt[v].size, vt[v].burst, 0);
    end

    // Long read with rready toggling every cycle.
    check_read(32'h0, 15, 3'd3, 2'd1, 1);

    // Simultaneous AW and AR: write wins, read waits for the B handshake.
    wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
    mdl_write(32'h600, 0, 3'd3, 2'd1, 0, r);
    awaddr = 32'h600; awlen = 4'd0; awsize = 3'd3; awburst = 2'd1;
    araddr = 32'h600; arlen = 4'd0; arsize = 3'd3; arburst = 2'd1;
    awvalid = 1'b1; arvalid = 1'b1;
    #1;
    check("sim_awready", 64'(awready), 64'(1));
    check("sim_arready", 64'(arready), 64'(0));
    @(posedge aclk); #1;
    awvalid = 1'b0;
    check("sim_w_phase", 64'(wready), 64'(1));
    check("sim_ar_blocked_w", 64'(arready), 64'(0));
    wvalid = 1'b1; wdata = wd[0]; wstrb = 8'hFF; wlast = 1'b1;
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0;
    check("sim_bvalid", 64'(bvalid), 64'(1));
    check("sim_ar_blocked_b", 64'(arready), 64'(0));
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    check("sim_no_early_r", 64'(rvalid), 64'(0));
    check("sim_arready_after_b", 64'(arready), 64'(1));
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("sim_rvalid", 64'(rvalid), 64'(1));
    check("sim_rdata", rdata, wd[0]);
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;

    // Write crossing the top of memory.
    wd[0] = {$urandom, $urandom}; wd[1] = {$urandom, $urandom}; ws[0] = 8'hFF; ws[1] = 8'hFF;
    write_chk(32'(MEMB - 8), 1, 3'd3, 2'd1, 0, r);
    check("top_bresp", 64'(r), 64'(3));
    check_read(32'(MEMB - 8), 0, 3'd3, 2'd1, 0);
    check("top_beat0", rd_data[0], wd[0]);

    // wlast missing, then wlast early: SLVERR but data still lands.
    for (int m = 1; m <= 2; m++) begin
      for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      write_chk(32'h100, 3, 3'd3, 2'd1, m, r);
      check($sformatf("wlast_mode%0d_bresp", m), 64'(r), 64'(2));
      check_read(32'h100, 3, 3'd3, 2'd1, 0);
    end

    // Reset during beat 2 of an 8-beat write.
    for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    awaddr = 32'h500; awlen = 4'd7; awsize = 3'd3; awburst = 2'd1; awvalid = 1'b1;
    #1;
    check("rst_mid_awready", 64'(awready), 64'(1));
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = 8'hFF; wlast = 1'b0;
      @(posedge aclk); #1;
    end
    wvalid = 1'b1; wdata = wd[2];
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0; wvalid = 1'b0;
    check("rst_mid_bvalid", 64'(bvalid), 64'(0));
    check("rst_mid_wready", 64'(wready), 64'(0));
    check("rst_mid_idle", 64'(awready), 64'(1));
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < 8; b++) mdl[(32'h500 / 8 + i) * 8 + b] = wd[i][8*b +: 8];
    end
    check_read(32'h500, 1, 3'd3, 2'd1, 0);
    check("rst_kept0", rd_data[0], wd[0]);
    check("rst_kept1", rd_data[1], wd[1]);

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      logic [2:0] sz;
      logic [1:0] bu;
      a   = 32'($urandom_range(0, 280) * 8);
      len = $urandom_range(0, 15);
      sz  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'd3;
      bu  = ($urandom_range(0, 9) == 0) ? 2'd2 : (($urandom_range(0, 3) == 0) ? 2'd0 : 2'd1);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          wd[i] = {$urandom, $urandom};
          ws[i] = 8'($urandom_range(0, 255));
        end
        write_chk(a, len, sz, bu, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0, r);
      end else begin
        check_read(a, len, sz, bu, $urandom_range(0, 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 Parameter ADDR_W, 32, address width.
REQ-002 Parameter DATA_W, 64, data width; 8, 16, 32 or 64 only.
REQ-003 Parameter DEPTH, 256, memory depth in DATA_W words; power of two.
REQ-004 Parameter BASE_ADDR, 0, byte address of word 0; aligned to DEPTH*DATA_W/8.
REQ-005 aclk  in  1  sole clock; all logic on the rising edge.
REQ-006 areset  in  1  reset, synchronous to aclk, active-high.
REQ-007 s_axi_awaddr  in  ADDR_W  write burst start byte address.
REQ-008 s_axi_awlen / s_axi_awsize / s_axi_awburst  in  4/3/2  beats-1, beat size, burst type.
REQ-009 s_axi_awprot / s_axi_awcache / s_axi_awlock / s_axi_awqos / s_axi_awregion  in  3/4/1/4/4  accepted, ignored.
REQ-010 s_axi_awvalid  in  1 ; s_axi_awready  out  1  write-address handshake.
REQ-011 s_axi_wdata  in  DATA_W ; s_axi_wstrb  in  DATA_W/8 ; s_axi_wlast  in  1  write beat data, byte enables, last flag.
REQ-012 s_axi_wvalid  in  1 ; s_axi_wready  out  1  write-data handshake.
REQ-013 s_axi_bresp  out  2 ; s_axi_bvalid  out  1 ; s_axi_bready  in  1  write response.
REQ-014 s_axi_araddr / s_axi_arlen / s_axi_arsize / s_axi_arburst  in  ADDR_W/4/3/2  read burst descriptor.
REQ-015 s_axi_arprot / s_axi_arcache / s_axi_arlock / s_axi_arqos / s_axi_arregion  in  3/4/1/4/4  accepted, ignored.
REQ-016 s_axi_arvalid  in  1 ; s_axi_arready  out  1  read-address handshake.
REQ-017 s_axi_rdata  out  DATA_W ; s_axi_rresp  out  2 ; s_axi_rlast  out  1 ; s_axi_rvalid  out  1 ; s_axi_rready  in  1  read data channel.

Function
REQ-018 The FSM SHALL have states IDLE, WDATA, WRESP and RDATA, with one burst outstanding at a time.
REQ-019 awready SHALL be (state==IDLE) and arready SHALL be (state==IDLE && !awvalid), both combinational, so ready precedes valid and a simultaneous AW+AR accepts the write only.
REQ-020 On an AW handshake the block SHALL latch addr/len/size/burst, clear the 4-bit beat counter, check the descriptor and go to WDATA next cycle.
REQ-021 In WDATA, wready SHALL be 1; each wvalid&&wready beat SHALL write the bytes enabled by wstrb, then advance the address and counter.
REQ-022 The beat with counter==len SHALL end the burst and enter WRESP; wlast SHALL be checked, not used for termination.
REQ-023 In WRESP, bvalid SHALL be held at 1 with a stable bresp until bready, then the FSM SHALL return to IDLE; earliest bvalid is 1 cycle after the last W beat.
REQ-024 On an AR handshake the block SHALL latch the descriptor and enter RDATA, with rvalid=1 and beat-0 data registered on the next cycle (latency 1).
REQ-025 In RDATA, rdata/rresp/rlast SHALL hold stable while rvalid&&!rready.
REQ-026 On each rvalid&&rready in RDATA the next beat SHALL be presented the following cycle with no bubble.
REQ-027 rlast SHALL be 1 on beat counter==len; its handshake SHALL return the FSM to IDLE with rvalid=0.
REQ-028 INCR SHALL add 2^size per beat; FIXED SHALL keep the address constant; arithmetic is modulo 2^ADDR_W.
REQ-029 WRAP bursts, or size != log2(DATA_W/8), SHALL get SLVERR (2'b10): writes suppressed, read data 0, full beat count still handshaken.
REQ-030 A beat address outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8) SHALL get DECERR (2'b11), write suppressed, read data 0; the check is per beat.
REQ-031 A wlast mismatch (asserted early, or absent on the final beat) SHALL give SLVERR in bresp; data writes still occur.
REQ-032 bresp SHALL be the highest-priority error over the burst: DECERR > SLVERR > OKAY.
REQ-033 The word index SHALL be addr[log2(DATA_W/8) +: log2(DEPTH)] after subtracting BASE_ADDR.

Reset
REQ-034 While areset=1 at a clock edge: state=IDLE, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, rdata=0, beat counter=0; wready=0; awready and arready become 1 after release.
REQ-035 Reset mid-burst SHALL abandon the burst without a response; memory contents are not reset and writes already completed are kept.

Structure
REQ-036 Shared package axi_pkg SHALL hold the resp codes (OKAY/EXOKAY/SLVERR/DECERR), burst codes (FIXED/INCR/WRAP) and the FSM state encoding.
REQ-037 One sub-module, axi_slave_ram, SHALL provide a DEPTH x DATA_W array with a byte-enable write port and a registered read port.

Verification
REQ-038 Write INCR, addr 0x0, len 3, data 0x11..0x44, strb 0xFF, then read the same burst -> bresp OKAY and rdata 0x11,0x22,0x33,0x44 with rlast on beat 3.
REQ-039 Write addr 0x8 with strb 0x0F over 0xFFFF_FFFF_FFFF_FFFF, data 0x0 -> readback 0xFFFF_FFFF_0000_0000.
REQ-040 Read len 15 with rready toggled 1/0 every cycle -> 16 beats in order, values stable during stalls, exactly one rlast.
REQ-041 AW and AR valid in the same cycle at IDLE -> only awready handshakes, and AR is accepted after the bvalid&&bready handshake.
REQ-042 Write INCR from the last word, addr DEPTH*8-8, len 1 -> beat 0 written, beat 1 suppressed, bresp DECERR.
REQ-043 areset pulsed for 1 cycle during WDATA beat 2 of len 7 -> next cycle in IDLE, bvalid=0, beats 0-1 retained in memory.
